pcd_miller_sequencer: RTL
=========================

// Module: pcd_miller_sequencer
// PURPOSE
//  Reader-side (PCD) TX sequencer for ISO/IEC 14443A 106 kbps modified-Miller signalling.
//  Runs on the 13.56 MHz carrier clock and accepts a frame of bits over a valid/ready stream.
//  Drives pause_n, the carrier-enable that gates the analogue carrier in the bench/AFE model.
//  Sequences SOC, data bits and EOC as X/Y/Z sequences, one per bit period.
// PARAMETERS
//  BIT_CYCLES    128  carrier cycles per bit period (sequence length)
//  PAUSE_CYCLES   28  pause length in carrier cycles; must be >0 and < BIT_CYCLES/2
//  X_OFFSET       64  pause start cycle within an X sequence (BIT_CYCLES/2)
// PORTS
//  clk        in   1  carrier clock (13.56 MHz)
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  pulse: begin a frame; sampled only in IDLE
//  bit_valid  in   1  bit_data/bit_last valid
//  bit_data   in   1  next frame bit
//  bit_last   in   1  current bit is the final data bit of the frame
//  bit_ready  out  1  bit accepted this cycle if bit_valid=1
//  pause_n    out  1  carrier enable: 0 = carrier paused
//  busy       out  1  frame in progress (state != IDLE)
//  done       out  1  one-cycle pulse: frame complete
//  underrun   out  1  qualifies done: frame aborted because no bit was offered
// BEHAVIOUR
//  Reset: state IDLE; cnt=0; pause_n=1; bit_ready=0; busy=0; done=0; underrun=0; prev_zero=0.
//  Reset asserted mid-frame forces pause_n=1 immediately (asynchronously). No done is issued.
//  Sequences: each lasts BIT_CYCLES cycles; cnt runs 0..BIT_CYCLES-1 and wraps to 0.
//   Z: pause_n=0 for cnt 0..PAUSE_CYCLES-1.
//   X: pause_n=0 for cnt X_OFFSET..X_OFFSET+PAUSE_CYCLES-1.
//   Y: pause_n=1 throughout.
//  pause_n is registered: its value in the cycle with cnt=k reflects the window for k.
//  States:
//   IDLE: start=1 -> SOC. Sequence begins the next cycle with cnt=0.
//   SOC: emits Z; sets prev_zero=1.
//   DATA: emits one bit.
//    bit 1 -> X; clears prev_zero.
//    bit 0 -> Z if prev_zero, else Y; sets prev_zero.
//   EOC0: emits logic 0 using the same rule (Z if prev_zero, else Y).
//   EOCY: emits Y. On cnt=BIT_CYCLES-1: done=1 for one cycle; next state IDLE.
//  Transitions at cnt=BIT_CYCLES-1:
//   SOC or DATA without bit_last -> bit_ready=1 this cycle.
//    bit_valid=1: DATA with the accepted bit.
//    bit_valid=0: EOC0, and underrun latched.
//   DATA whose bit had bit_last=1 -> EOC0 (bit_ready stays 0).
//   EOC0 -> EOCY.
//  bit_ready is high only in those single cycles. Data is captured on the same edge.
//  underrun stays high from the latch until the done pulse, inclusive. It clears when IDLE is entered.
//  start is ignored while busy=1. A start in the cycle after done begins a new frame.
//  Sequences are gapless: the next sequence's cnt=0 directly follows cnt=BIT_CYCLES-1.
//  Counter width: $clog2(BIT_CYCLES). No other arithmetic is needed.
// TESTING
//  1. start at T, then bit 1 with last -> sequences Z,X,Y,Y.
//     pause_n=0 at T+1..T+28 and T+193..T+220 only; done at T+512.
//  2. Bits 0,0,1,0 (last on the 4th) -> sequences Z,Z,Z,X,Y,Z,Y.
//     Pause starts at T+1, T+129, T+257, T+449 and T+641; done at T+896.
//  3. start, bit_valid never asserted -> Z then EOC0=Z, then Y.
//     bit_ready pulses once at T+128; underrun=1 with done at T+384.
//  4. rst_n low at cnt=10 of the SOC Z -> pause_n=1 and busy=0 before the next edge.
//     After release, outputs are at reset values; start works normally.
//  5. start re-pulsed mid-frame -> no effect. start in the cycle after done -> new SOC Z.
//  6. Param BIT_CYCLES=16, PAUSE_CYCLES=3 -> scenario 1 timing scales.
//     Pauses at T+1..T+3 and T+25..T+27; done at T+64.

Source files
------------

// File: rtl/pcd_miller_sequencer.sv
// rtl/pcd_miller_sequencer.sv - ISO 14443A 106 kbps modified-Miller PCD TX sequencer
// Emits SOC/data/EOC as Z/X/Y bit periods on pause_n, pulling frame bits over a valid/ready stream.
module pcd_miller_sequencer #(
  parameter int BIT_CYCLES   = 128,
  parameter int PAUSE_CYCLES = 28,
  parameter int X_OFFSET     = BIT_CYCLES / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic bit_data,
  input  logic bit_last,
  output logic bit_ready,
  output logic pause_n,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] Z_END    = CW'(PAUSE_CYCLES);
  localparam logic [CW-1:0] X_BEG    = CW'(X_OFFSET);
  localparam logic [CW-1:0] X_END    = CW'(X_OFFSET + PAUSE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOC  = 3'd1,
    S_DATA = 3'd2,
    S_EOC0 = 3'd3,
    S_EOCY = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEQ_Y = 2'd0,
    SEQ_X = 2'd1,
    SEQ_Z = 2'd2
  } seq_t;

  state_t        state, state_nxt;
  seq_t          seq, seq_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          prev_zero, prev_zero_nxt;
  logic          cur_last, cur_last_nxt;
  logic          underrun_nxt;
  logic          pause_n_nxt;
  logic          seq_end;
  logic          offer;
  seq_t          zero_seq;

  assign seq_end  = (cnt == CNT_LAST);
  assign zero_seq = prev_zero ? SEQ_Z : SEQ_Y;
  // A bit is requested only in the final cycle of SOC or of a data bit that was not the last one.
  assign offer    = seq_end && ((state == S_SOC) || ((state == S_DATA) && !cur_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      seq       <= SEQ_Y;
      cnt       <= '0;
      prev_zero <= 1'b0;
      cur_last  <= 1'b0;
      underrun  <= 1'b0;
      pause_n   <= 1'b1;
    end else begin
      state     <= state_nxt;
      seq       <= seq_nxt;
      cnt       <= cnt_nxt;
      prev_zero <= prev_zero_nxt;
      cur_last  <= cur_last_nxt;
      underrun  <= underrun_nxt;
      pause_n   <= pause_n_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    seq_nxt       = seq;
    prev_zero_nxt = prev_zero;
    cur_last_nxt  = cur_last;
    underrun_nxt  = underrun;
    cnt_nxt       = ((state == S_IDLE) || seq_end) ? '0 : (cnt + CNT_ONE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_SOC;
          seq_nxt       = SEQ_Z;
          prev_zero_nxt = 1'b1;
          cur_last_nxt  = 1'b0;
        end
      end
      S_SOC, S_DATA: begin
        if (seq_end) begin
          if (offer && bit_valid) begin
            state_nxt     = S_DATA;
            seq_nxt       = bit_data ? SEQ_X : zero_seq;
            prev_zero_nxt = !bit_data;
            cur_last_nxt  = bit_last;
          end else begin
            state_nxt     = S_EOC0;
            seq_nxt       = zero_seq;
            prev_zero_nxt = 1'b1;
            underrun_nxt  = underrun | offer;
          end
        end
      end
      S_EOC0: begin
        if (seq_end) begin
          state_nxt = S_EOCY;
          seq_nxt   = SEQ_Y;
        end
      end
      S_EOCY: begin
        if (seq_end) begin
          state_nxt    = S_IDLE;
          underrun_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        underrun_nxt = 1'b0;
      end
    endcase

    // pause_n is registered, so the window is evaluated for the cycle being entered.
    if (state_nxt == S_IDLE) begin
      pause_n_nxt = 1'b1;
    end else if (seq_nxt == SEQ_Z) begin
      pause_n_nxt = !(cnt_nxt < Z_END);
    end else if (seq_nxt == SEQ_X) begin
      pause_n_nxt = !((cnt_nxt >= X_BEG) && (cnt_nxt < X_END));
    end else begin
      pause_n_nxt = 1'b1;
    end
  end

  always_comb begin
    bit_ready = offer;
    busy      = (state != S_IDLE);
    done      = (state == S_EOCY) && seq_end;
  end

endmodule
